mac_dot_sequencer: RTL and testbench

//  Sequences one MAC datapath through a complete dot product of cfg_len operand pairs.
//  It accepts operand pairs on a valid/ready stream and clears the MAC before the first pair.
//  It issues one MAC op per accepted pair, waits out the MAC pipeline latency, then returns
//  the accumulator on a valid/ready result port. It sits between the CNN layer scheduler
//  and the MAC datapath.

---
 rtl/mac_seq_pkg.sv | 21 ++
 rtl/mac_seq_lat_ctr.sv | 23 ++
 rtl/mac_dot_sequencer.sv | 113 +++++++++++
 tb/tb_mac_dot_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and width helpers for the MAC dot-product sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Drain counter must hold MAC_LAT+1 distinct values (MAC_LAT down to 0).
  function automatic int drain_w(input int mac_lat);
    return $clog2(mac_lat + 2);
  endfunction

endpackage

// File: rtl/mac_seq_lat_ctr.sv
// Loadable down-counter that times the MAC pipeline drain; zero flags expiry.
module mac_seq_lat_ctr #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Drives one MAC datapath through a cfg_len-pair dot product and returns the sum.
// Optional MACSEQ_ABORT_EN adds an abort input that drops the job and clears the MAC.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ACC_W   = 2*WIDTH,
  parameter int MAX_LEN = 256,
  parameter int MAC_LAT = 1,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MACSEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [WIDTH-1:0] mac_x,
  output logic [WIDTH-1:0] mac_y,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  localparam int DRAIN_W = drain_w(MAC_LAT);

  state_t           state, state_nx;
  logic [LEN_W-1:0] len, issued;
  logic             abort_hit, accept, last_pair, lat_zero;

`ifdef MACSEQ_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept    = op_valid && op_ready;
  assign last_pair = (issued == len - LEN_W'(1));
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    op_ready = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = (cfg_len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nx = S_RUN;
      S_RUN: begin
        op_ready = 1'b1;
        if (op_valid && last_pair) state_nx = S_DRAIN;
      end
      S_DRAIN: if (lat_zero) state_nx = S_DONE;
      S_DONE:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort wins over every other transition, including the result handshake.
    if (abort_hit) begin
      state_nx = S_IDLE;
      op_ready = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len      <= '0;
      issued   <= '0;
      mac_x    <= '0;
      mac_y    <= '0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      res_data <= '0;
    end else begin
      mac_en  <= accept;
      mac_clr <= abort_hit || (state == S_IDLE && start && cfg_len != '0);
      if (state == S_IDLE && start) begin
        len    <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        issued <= '0;
        if (cfg_len == '0) res_data <= '0;
      end
      if (accept) begin
        mac_x  <= op_x;
        mac_y  <= op_y;
        issued <= issued + LEN_W'(1);
      end
      if (state == S_DRAIN && lat_zero && !abort_hit) res_data <= mac_acc;
    end
  end

  // Loaded on the last accepting edge; DRAIN then lasts MAC_LAT+1 cycles.
  mac_seq_lat_ctr #(.W(DRAIN_W)) u_lat_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && last_pair),
    .load_val (DRAIN_W'(MAC_LAT)),
    .dec      (state == S_DRAIN),
    .zero     (lat_zero)
  );

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized bench for mac_dot_sequencer; expected sums come from the pair tables.
module tb_mac_dot_sequencer;

  localparam int WIDTH   = 16;
  localparam int ACC_W   = 32;
  localparam int MAX_LEN = 256;
  localparam int MAC_LAT = 1;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy, op_valid, op_ready;
  logic [WIDTH-1:0] op_x, op_y, mac_x, mac_y;
  logic             mac_clr, mac_en, res_valid, res_ready;
  logic [ACC_W-1:0] mac_acc, res_data;
`ifdef MACSEQ_ABORT_EN
  logic             abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int clr_cnt = 0;

  logic [WIDTH-1:0] xs [MAX_LEN];
  logic [WIDTH-1:0] ys [MAX_LEN];

  always #5 clock = ~clock;

  mac_dot_sequencer #(
    .WIDTH(WIDTH), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .MAC_LAT(MAC_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef MACSEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_x      (op_x),
    .op_y      (op_y),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .mac_x     (mac_x),
    .mac_y     (mac_y),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-cycle-latency MAC stand-in.
  always @(posedge clock) begin
    if (mac_clr)     mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + 32'(mac_x) * 32'(mac_y);
  end

  always @(negedge clock) begin
    if (mac_en)  en_cnt++;
    if (mac_clr) clr_cnt++;
    if (mac_clr) chk("clr_en_excl", mac_en, 0);
  end

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      xs[i] = 16'($urandom);
      ys[i] = 16'($urandom);
    end
  endtask

  task automatic feed_pair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input string tag);
    bit ok, rdy;
    op_valid = 1'b1; op_x = x; op_y = y;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      rdy = op_ready;
      @(posedge clock); #1;
      ok = rdy;
    end
    if (!ok) chk({tag, "_hs_timeout"}, 0, 1);
  endtask

  task automatic run_job(input int cfg, input bit gaps, input bit poke_start,
                         input int hold, input string tag, output logic [ACC_W-1:0] got);
    int n, en0, clr0, w;
    logic [ACC_W-1:0] exp;
    n = (cfg > MAX_LEN) ? MAX_LEN : cfg;
    exp = '0;
    for (int i = 0; i < n; i++) exp += 32'(xs[i]) * 32'(ys[i]);
    en0 = en_cnt; clr0 = clr_cnt;
    start = 1'b1; cfg_len = LEN_W'(cfg);
    @(posedge clock); #1;
    start = 1'b0; cfg_len = '0;
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      if (poke_start && i == n/2) begin
        start = 1'b1; cfg_len = LEN_W'(2);
        @(posedge clock); #1;
        start = 1'b0; cfg_len = '0;
      end
      feed_pair(xs[i], ys[i], tag);
    end
    if (n > 0) chk({tag, "_rdy_drop"}, op_ready, 0);
    op_valid = 1'b0;
    w = 0;
    while (!res_valid && w < 20) begin @(posedge clock); #1; w++; end
    if (n > 0) chk({tag, "_drain_lat"}, w, MAC_LAT + 1);
    else       chk({tag, "_zero_lat"}, w <= 2, 1);
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_data"}, res_data, exp);
    got = res_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk({tag, "_hold"}, {res_valid, res_data}, {1'b1, exp});
    end
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    chk({tag, "_idle"}, {busy, res_valid}, 0);
    chk({tag, "_n_en"}, en_cnt - en0, n);
    chk({tag, "_n_clr"}, clr_cnt - clr0, (n > 0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] got;
    reset = 1'b1; start = 1'b0; cfg_len = '0; op_valid = 1'b0;
    op_x = '0; op_y = '0; res_ready = 1'b0;
`ifdef MACSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ctrl", {busy, op_ready, mac_en, mac_clr, res_valid}, 0);
    chk("rst_data", {res_data, mac_x, mac_y}, 0);
    reset = 1'b0;

    // Fixed operand tables: pairwise reading, then vector reading x=1..4, y=5..8.
    xs[0] = 1; ys[0] = 2; xs[1] = 3; ys[1] = 4;
    xs[2] = 5; ys[2] = 6; xs[3] = 7; ys[3] = 8;
    run_job(4, 0, 0, 3, "t1_pairs", got);
    chk("t1_pairs_100", got, 100);
    xs[0] = 1; ys[0] = 5; xs[1] = 2; ys[1] = 6;
    xs[2] = 3; ys[2] = 7; xs[3] = 4; ys[3] = 8;
    run_job(4, 0, 0, 1, "t1_vec", got);
    chk("t1_vec_70", got, 70);

    run_job(0, 0, 0, 2, "t2_len0", got);

    fill_rand(3);
    run_job(3, 1, 0, 5, "t3_gaps", got);

    fill_rand(MAX_LEN);
    run_job(4, 0, 1, 0, "t4_poke", got);
    run_job(MAX_LEN + 5, 0, 0, 0, "t4_sat", got);

    fill_rand(4);
    start = 1'b1; cfg_len = LEN_W'(4);
    @(posedge clock); #1;
    start = 1'b0; cfg_len = '0;
    feed_pair(xs[0], ys[0], "t5_pre");
    feed_pair(xs[1], ys[1], "t5_pre");
    op_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t5_rst_ctrl", {busy, op_ready, mac_en, mac_clr, res_valid}, 0);
    chk("t5_rst_data", {res_data, mac_x, mac_y}, 0);
    fill_rand(4);
    run_job(4, 0, 0, 0, "t5_fresh", got);

`ifdef MACSEQ_ABORT_EN
    fill_rand(3);
    start = 1'b1; cfg_len = LEN_W'(3);
    @(posedge clock); #1;
    start = 1'b0; cfg_len = '0;
    for (int i = 0; i < 3; i++) feed_pair(xs[i], ys[i], "t6_pre");
    op_valid = 1'b0; abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("t6_abort_state", {busy, op_ready, res_valid, mac_en}, 0);
    chk("t6_abort_clr", mac_clr, 1);
    @(posedge clock); #1;
    chk("t6_clr_once", mac_clr, 0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("t6_no_result", {busy, res_valid}, 0);
    end
    fill_rand(3);
    run_job(3, 0, 0, 0, "t6_next", got);
`endif

    for (int j = 0; j < 8; j++) begin
      int len;
      len = $urandom_range(1, 12);
      fill_rand(len);
      run_job(len, 1, 0, $urandom_range(0, 4), "rnd", got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
